// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: multi-cycle unsigned N x N -> 2N shift-and-add multiplier
//
// One N-bit ripple adder is time-shared: each RUN cycle adds one partial
// product into the high half and shifts the {hi, lo} pair right by one.
//
// Optional feature macro: ZERO_BYPASS_EN
//   defined   -> a zero operand skips RUN and completes on the next edge
//   undefined -> every operation spends N cycles in RUN
//
// Ports:
//   clk        clock, all state changes on its rising edge
//   rst        synchronous active-high reset
//   start_i    request, sampled only in IDLE or DONE
//   a_i        multiplicand, captured when start_i is accepted
//   b_i        multiplier, captured when start_i is accepted
//   busy_o     high while the sequencer is in RUN
//   done_o     one-cycle pulse, high exactly while in DONE
//   product_o  registered 2N-bit result, held until the next completion
//   zero_o     registered product_o == 0, updated with product_o

module shift_add_mult_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] num1_i,
    input  logic [N-1:0] num2_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);
    logic [N:0] c;
    assign c[0] = cin_i;
    for (genvar g = 0; g < N; g++) begin : g_fa
        assign sum_o[g] = num1_i[g] ^ num2_i[g] ^ c[g];
        assign c[g+1]   = (num1_i[g] & num2_i[g]) | (c[g] & (num1_i[g] ^ num2_i[g]));
    end
    assign cout_o = c[N];
endmodule

module shift_add_mult_ctrl #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [2*N-1:0] product_o,
    output logic           zero_o
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q;
    logic [N-1:0]   hi_q, lo_q, mcand_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q, done_q, zero_q;
    logic [2*N-1:0] product_q;

    logic [N-1:0]   num2, sum;
    logic           cout;
    logic [N-1:0]   hi_d, lo_d;
    logic           bypass;

    // Partial product is the multiplicand gated by the current multiplier LSB.
    assign num2 = lo_q[0] ? mcand_q : '0;

    shift_add_mult_adder #(.N(N)) u_adder (
        .num1_i (hi_q),
        .num2_i (num2),
        .cin_i  (1'b0),
        .sum_o  (sum),
        .cout_o (cout)
    );

    // Carry-out becomes the new MSB of hi; sum LSB shifts into lo.
    assign hi_d = {cout, sum[N-1:1]};
    assign lo_d = {sum[0], lo_q[N-1:1]};

`ifdef ZERO_BYPASS_EN
    assign bypass = (a_i == '0) || (b_i == '0);
`else
    assign bypass = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            zero_q    <= 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N-1)) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        product_q <= {hi_d, lo_d};
                        zero_q    <= ({hi_d, lo_d} == '0);
                    end
                end
                IDLE, DONE: begin
                    if (start_i) begin
                        mcand_q <= a_i;
                        lo_q    <= b_i;
                        hi_q    <= '0;
                        cnt_q   <= '0;
                        if (bypass) begin
                            state_q   <= DONE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            product_q <= '0;
                            zero_q    <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = product_q;
    assign zero_o    = zero_q;
endmodule
